rtc_time_counter: RTL and testbench

Parametrised time-of-day counter: second/minute/hour chain driven by a configurable clock divider. Adds run/stop control, a validated time-load handshake, 12/24-hour presentation and rollover strobes. Sits between the system clock and the `segment_show` display path, replacing the fixed 16-bit divider and free-running counter chain in the top level.

---
 rtl/rtc_pkg.sv | 30 +++
 rtl/rtc_mod_counter.sv | 45 ++++
 rtl/rtc_time_counter.sv | 184 ++++++++++++++++++
 tb/tb_rtc_time_counter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared types and constants for the time-of-day counter: FSM states,
// field limits and widths, and the 24h to 12h hour conversion.
package rtc_pkg;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } rtc_state_t;

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;
    localparam int HOUR_12  = 12;

    localparam int SEC_W  = 6;
    localparam int HOUR_W = 5;

    // Midnight is shown as 12; afternoon hours fold back into 1..11.
    function automatic logic [HOUR_W-1:0] hour_to_12h(input logic [HOUR_W-1:0] h);
        if (h == '0) begin
            return HOUR_W'(HOUR_12);
        end else if (h > HOUR_W'(HOUR_12)) begin
            return h - HOUR_W'(HOUR_12);
        end else begin
            return h;
        end
    endfunction

endpackage

// File: rtl/rtc_mod_counter.sv
// Modulo-(MAX+1) counter with parallel load; carry is combinational and
// flags the increment that wraps MAX back to zero.
module rtc_mod_counter
    import rtc_pkg::*;
#(
    parameter int MAX = 59,
    parameter int W   = 6
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         carry
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;
    logic         at_max;

    assign at_max = (value_q == MAX_V);
    assign carry  = inc && at_max;
    assign value  = value_q;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_val;
        end else if (inc) begin
            value_d = at_max ? '0 : value_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/rtc_time_counter.sv
// Time-of-day counter: divider, run/stop/hold FSM, validated load and
// rollover strobes. Define RTC_ALARM_EN to add the hour:minute alarm.
module rtc_time_counter
    import rtc_pkg::*;
#(
    parameter int TICKS_PER_SEC = 65536,
    parameter int DIV_W         = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    input  logic              mode_12h,
    input  logic              set_valid,
    input  logic [SEC_W-1:0]  set_sec,
    input  logic [SEC_W-1:0]  set_min,
    input  logic [HOUR_W-1:0] set_hour,
    output logic              set_ready,
    output logic              set_err,
    output logic [SEC_W-1:0]  sec,
    output logic [SEC_W-1:0]  min,
    output logic [HOUR_W-1:0] hour,
    output logic [HOUR_W-1:0] hour_disp,
    output logic              pm,
    output logic              sec_tick,
    output logic              min_tick,
    output logic              hour_tick,
    output logic              day_tick
`ifdef RTC_ALARM_EN
    ,
    input  logic              alarm_en,
    input  logic [HOUR_W-1:0] alarm_hour,
    input  logic [SEC_W-1:0]  alarm_min,
    output logic              alarm_hit
`endif
);

    localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(TICKS_PER_SEC - 1);

    rtc_state_t       state_q;
    rtc_state_t       state_d;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             set_in_range;
    logic             load_accept;
    logic             load_ok;
    logic             count_en;
    logic             div_tc;
    logic             sec_inc;
    logic             sec_carry;
    logic             min_carry;
    logic             hour_carry;
    logic             sec_tick_q;
    logic             min_tick_q;
    logic             hour_tick_q;
    logic             day_tick_q;
    logic             set_err_q;

    assign set_in_range = (set_sec  <= SEC_W'(SEC_MAX))
                       && (set_min  <= SEC_W'(MIN_MAX))
                       && (set_hour <= HOUR_W'(HOUR_MAX));
    assign load_accept  = set_valid && set_ready;
    assign load_ok      = load_accept && set_in_range;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_STOP;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (load_ok) begin
            state_d = ST_HOLD;
        end else begin
            case (state_q)
                ST_STOP: if (run)  state_d = ST_RUN;
                ST_RUN:  if (!run) state_d = ST_STOP;
                ST_HOLD: state_d = run ? ST_RUN : ST_STOP;
                default: state_d = ST_STOP;
            endcase
        end
    end

    // The divider steps on every edge that lands in ST_RUN, so run takes
    // effect on the very next edge and a load restarts a full second.
    always_comb begin
        set_ready = (state_q != ST_HOLD);
        count_en  = (state_d == ST_RUN);
    end

    assign div_tc  = (div_q == DIV_TC);
    assign sec_inc = count_en && div_tc;

    always_comb begin
        div_d = div_q;
        if (load_ok) begin
            div_d = '0;
        end else if (count_en) begin
            div_d = div_tc ? '0 : div_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            div_q       <= '0;
            sec_tick_q  <= 1'b0;
            min_tick_q  <= 1'b0;
            hour_tick_q <= 1'b0;
            day_tick_q  <= 1'b0;
            set_err_q   <= 1'b0;
        end else begin
            div_q       <= div_d;
            sec_tick_q  <= sec_inc;
            min_tick_q  <= sec_carry;
            hour_tick_q <= min_carry;
            day_tick_q  <= hour_carry;
            set_err_q   <= load_accept && !set_in_range;
        end
    end

    rtc_mod_counter #(.MAX(SEC_MAX), .W(SEC_W)) u_sec (
        .clock    (clock),
        .reset    (reset),
        .inc      (sec_inc),
        .load     (load_ok),
        .load_val (set_sec),
        .value    (sec),
        .carry    (sec_carry)
    );

    rtc_mod_counter #(.MAX(MIN_MAX), .W(SEC_W)) u_min (
        .clock    (clock),
        .reset    (reset),
        .inc      (sec_carry),
        .load     (load_ok),
        .load_val (set_min),
        .value    (min),
        .carry    (min_carry)
    );

    rtc_mod_counter #(.MAX(HOUR_MAX), .W(HOUR_W)) u_hour (
        .clock    (clock),
        .reset    (reset),
        .inc      (min_carry),
        .load     (load_ok),
        .load_val (set_hour),
        .value    (hour),
        .carry    (hour_carry)
    );

    assign sec_tick  = sec_tick_q;
    assign min_tick  = min_tick_q;
    assign hour_tick = hour_tick_q;
    assign day_tick  = day_tick_q;
    assign set_err   = set_err_q;

    assign hour_disp = mode_12h ? hour_to_12h(hour) : hour;
    assign pm        = mode_12h && (hour >= HOUR_W'(HOUR_12));

`ifdef RTC_ALARM_EN
    logic [SEC_W-1:0]  min_next;
    logic [HOUR_W-1:0] hour_next;
    logic              alarm_hit_q;

    // Match against the time about to be shown, so the hit lines up with
    // sec_tick; only a counting minute rollover (seconds -> 0) can match.
    assign min_next  = (min == SEC_W'(MIN_MAX)) ? '0 : min + 1'b1;
    assign hour_next = min_carry ? ((hour == HOUR_W'(HOUR_MAX)) ? '0 : hour + 1'b1) : hour;

    always_ff @(posedge clock) begin
        if (reset) begin
            alarm_hit_q <= 1'b0;
        end else begin
            alarm_hit_q <= alarm_en && sec_carry
                        && (min_next == alarm_min) && (hour_next == alarm_hour);
        end
    end

    assign alarm_hit = alarm_hit_q;
`endif

endmodule

// File: tb/tb_rtc_time_counter.sv
// Bench for rtc_time_counter with a seconds-of-day reference model checked
// every cycle, plus directed loads/pauses with literal expectations.
module tb_rtc_time_counter;

    localparam int T = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       run;
    logic       mode_12h;
    logic       set_valid;
    logic [5:0] set_sec;
    logic [5:0] set_min;
    logic [4:0] set_hour;
    logic       set_ready;
    logic       set_err;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic [4:0] hour_disp;
    logic       pm;
    logic       sec_tick;
    logic       min_tick;
    logic       hour_tick;
    logic       day_tick;
`ifdef RTC_ALARM_EN
    logic       alarm_en;
    logic [4:0] alarm_hour;
    logic [5:0] alarm_min;
    logic       alarm_hit;
`endif

    always #5 clock = ~clock;

    rtc_time_counter #(.TICKS_PER_SEC(T), .DIV_W(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .run       (run),
        .mode_12h  (mode_12h),
        .set_valid (set_valid),
        .set_sec   (set_sec),
        .set_min   (set_min),
        .set_hour  (set_hour),
        .set_ready (set_ready),
        .set_err   (set_err),
        .sec       (sec),
        .min       (min),
        .hour      (hour),
        .hour_disp (hour_disp),
        .pm        (pm),
        .sec_tick  (sec_tick),
        .min_tick  (min_tick),
        .hour_tick (hour_tick),
        .day_tick  (day_tick)
`ifdef RTC_ALARM_EN
        ,
        .alarm_en   (alarm_en),
        .alarm_hour (alarm_hour),
        .alarm_min  (alarm_min),
        .alarm_hit  (alarm_hit)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: time as seconds since midnight plus divider phase.
    int m_tod   = 0;
    int m_phase = 0;
    bit m_hold  = 0;
    bit m_err   = 0;
    bit m_st    = 0;
    bit m_mt    = 0;
    bit m_ht    = 0;
    bit m_dt    = 0;
    bit m_al    = 0;
    bit chk_en  = 0;

    always @(posedge clock) begin
        int tod;
        int ph;
        bit hold, err, st, mt, ht, dt, al;
        tod = m_tod; ph = m_phase;
        hold = 0; err = 0; st = 0; mt = 0; ht = 0; dt = 0; al = 0;
        if (reset) begin
            tod = 0;
            ph  = 0;
        end else if (set_valid && !m_hold && set_sec <= 59 && set_min <= 59 && set_hour <= 23) begin
            tod  = int'(set_hour) * 3600 + int'(set_min) * 60 + int'(set_sec);
            ph   = 0;
            hold = 1;
        end else begin
            err = set_valid && !m_hold;
            if (run) begin
                ph++;
                if (ph == T) begin
                    ph  = 0;
                    tod = (tod + 1) % 86400;
                    st  = 1;
                    mt  = (tod % 60 == 0);
                    ht  = (tod % 3600 == 0);
                    dt  = (tod == 0);
`ifdef RTC_ALARM_EN
                    al  = alarm_en && (tod == int'(alarm_hour) * 3600 + int'(alarm_min) * 60);
`endif
                end
            end
        end
        m_tod   <= tod;
        m_phase <= ph;
        m_hold  <= hold;
        m_err   <= err;
        m_st    <= st;
        m_mt    <= mt;
        m_ht    <= ht;
        m_dt    <= dt;
        m_al    <= al;
        chk_en  <= chk_en | reset;
    end

    always @(negedge clock) begin
        if (chk_en) begin
            int h;
            h = m_tod / 3600;
            check("sec", sec, m_tod % 60);
            check("min", min, (m_tod / 60) % 60);
            check("hour", hour, h);
            check("set_ready", set_ready, !m_hold);
            check("set_err", set_err, m_err);
            check("sec_tick", sec_tick, m_st);
            check("min_tick", min_tick, m_mt);
            check("hour_tick", hour_tick, m_ht);
            check("day_tick", day_tick, m_dt);
            check("hour_disp", hour_disp, mode_12h ? ((h % 12 == 0) ? 12 : h % 12) : h);
            check("pm", pm, mode_12h && h >= 12);
`ifdef RTC_ALARM_EN
            check("alarm_hit", alarm_hit, m_al);
`endif
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_load(input int h, input int m, input int s);
        set_valid = 1'b1;
        set_hour  = 5'(h);
        set_min   = 6'(m);
        set_sec   = 6'(s);
        step(1);
        set_valid = 1'b0;
        $display("load %0d:%0d:%0d -> now %0d:%0d:%0d ready=%0d err=%0d",
                 h, m, s, hour, min, sec, set_ready, set_err);
    endtask

    initial begin
        reset = 1'b1; run = 1'b1; mode_12h = 1'b0; set_valid = 1'b0;
        set_sec = '0; set_min = '0; set_hour = '0;
`ifdef RTC_ALARM_EN
        alarm_en = 1'b0; alarm_hour = '0; alarm_min = '0;
`endif
        step(2);
        reset = 1'b0;
        $display("reset released");
        check("reset_ready", set_ready, 1);
        check("reset_sec", sec, 0);
        check("reset_hour_disp", hour_disp, 0);

        step(3);
        check("pre_first_tick", sec_tick, 0);
        step(1);
        check("first_tick", sec_tick, 1);
        check("sec_after_4", sec, 1);
        step(4);
        check("sec_after_8", sec, 2);

        do_load(23, 59, 59);
        check("load_hour", hour, 23);
        check("load_ready_low", set_ready, 0);
        step(3);
        check("pre_wrap_sec", sec, 59);
        step(1);
        $display("day wrap -> %0d:%0d:%0d", hour, min, sec);
        check("wrap_time", {hour, min, sec}, 0);
        check("wrap_strobes", {sec_tick, min_tick, hour_tick, day_tick}, 4'b1111);

        do_load(0, 60, 0);
        check("bad_err", set_err, 1);
        check("bad_ready", set_ready, 1);
        check("bad_min", min, 0);
        step(1);
        check("bad_err_clear", set_err, 0);

        do_load(12, 34, 56);
        check("good_time", {hour, min, sec}, {5'd12, 6'd34, 6'd56});
        check("good_ready_low", set_ready, 0);
        step(1);
        check("good_ready_back", set_ready, 1);

        do_load(1, 0, 0);
        step(2);
        run = 1'b0;
        $display("pause");
        step(10);
        check("paused_sec", sec, 0);
        run = 1'b1;
        $display("resume");
        step(1);
        check("resume_no_tick", sec_tick, 0);
        step(1);
        check("resume_tick", sec_tick, 1);
        check("resume_sec", sec, 1);

        mode_12h = 1'b1;
        do_load(0, 0, 0);
        check("h12_0_disp", hour_disp, 12);
        check("h12_0_pm", pm, 0);
        step(1);
        do_load(12, 0, 0);
        check("h12_12_disp", hour_disp, 12);
        check("h12_12_pm", pm, 1);
        step(1);
        do_load(13, 0, 0);
        check("h12_13_disp", hour_disp, 1);
        check("h12_13_pm", pm, 1);
        mode_12h = 1'b0;
        step(1);

        do_load(2, 0, 0);
        step(3);
        do_load(5, 6, 7);
        check("tc_load_time", {hour, min, sec}, {5'd5, 6'd6, 6'd7});
        check("tc_load_no_tick", sec_tick, 0);
        step(3);
        check("tc_pre_tick", sec_tick, 0);
        step(1);
        check("tc_tick", sec_tick, 1);
        check("tc_sec", sec, 8);

        do_load(9, 9, 9);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        $display("reset during hold");
        check("hold_reset_ready", set_ready, 1);
        check("hold_reset_time", {hour, min, sec}, 0);

        run = 1'b0;
        step(2);
        do_load(3, 3, 3);
        step(6);
        check("stopped_sec", sec, 3);
        run = 1'b1;
        step(2);

`ifdef RTC_ALARM_EN
        alarm_en = 1'b1; alarm_hour = 5'd0; alarm_min = 6'd1;
        do_load(0, 0, 58);
        step(4);
        check("alarm_early", alarm_hit, 0);
        step(4);
        $display("alarm check at %0d:%0d:%0d hit=%0d", hour, min, sec, alarm_hit);
        check("alarm_hit", alarm_hit, 1);
        check("alarm_min", min, 1);
        step(1);
        check("alarm_once", alarm_hit, 0);
        alarm_en = 1'b0;
`endif

        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
